dm_operand_loader: RTL

DM_OPERAND_LOADER -- requirements
Module: dm_operand_loader

---
 rtl/dm_operand_loader.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/dm_operand_loader.sv
// -----------------------------------------------------------------------------
// dm_operand_loader
//
// Purpose:
//   Loads two 4-bit switch operands into a CPU data memory and supervises one
//   CPU run. A debounced press of btn_go captures sw_a/sw_b. The block then
//   writes A and B to data memory on two consecutive cycles and releases the
//   CPU. It waits for cpu_done, or gives up after TIMEOUT run cycles, and
//   reports the outcome in DONE.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous active-low reset
//   sw_a         in   4   operand A switches {a4,a3,a2,a1}
//   sw_b         in   4   operand B switches {b4,b3,b2,b1}
//   btn_go       in   1   raw asynchronous start button, active-high
//   cpu_done     in   1   CPU finished storing its result (level or pulse)
//   dm_we        out  1   data-memory write strobe, one cycle per word
//   dm_addr      out  7   data-memory word address
//   dm_wdata     out  32  data-memory write data (operand zero-extended)
//   cpu_run      out  1   1 = CPU released, 0 = CPU held in reset
//   busy         out  1   high in WRITE_A, WRITE_B, RUN
//   result_valid out  1   high in DONE after a normal completion
//   timeout_err  out  1   high in DONE after a timed-out run
//   dbg_state_o  out  3   current FSM state, for observation only
//
// Handshake: there is no back-pressure. Each dm_we cycle is one accepted word.
// cpu_done is sampled only while in RUN. Any go pulse seen outside IDLE/DONE
// is dropped, not held over.
// -----------------------------------------------------------------------------
module dm_operand_loader #(
    parameter logic [15:0] DB_LIMIT = 16'd50000,
    parameter logic [23:0] TIMEOUT  = 24'd1000000,
    parameter logic [6:0]  A_ADDR   = 7'd0,
    parameter logic [6:0]  B_ADDR   = 7'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sw_a,
    input  logic [3:0]  sw_b,
    input  logic        btn_go,
    input  logic        cpu_done,
    output logic        dm_we,
    output logic [6:0]  dm_addr,
    output logic [31:0] dm_wdata,
    output logic        cpu_run,
    output logic        busy,
    output logic        result_valid,
    output logic        timeout_err,
    output logic [2:0]  dbg_state_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WRITE_A = 3'd1;
    localparam logic [2:0] S_WRITE_B = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    // ------------------------------------------------------------------
    // Button path: 2-flop synchronizer, debouncer, rising-edge detector
    // ------------------------------------------------------------------
    logic        sync1_q, sync2_q;
    logic        db_level_q, db_level_d;
    logic [15:0] db_cnt_q, db_cnt_d;
    logic        go_q, go_d;

    // The counter runs only while the synchronized level disagrees with the
    // accepted level. Any cycle of agreement (a bounce back) restarts it.
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q >= DB_LIMIT - 16'd1) begin
                db_level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 16'd1;
            end
        end
    end

    // A go pulse fires only on the accepted 0->1 change. Release is silent.
    assign go_d = db_level_d & ~db_level_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            go_q       <= 1'b0;
        end else begin
            sync1_q    <= btn_go;
            sync2_q    <= sync1_q;
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            go_q       <= go_d;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic [2:0]  state_q, state_d;
    logic [3:0]  op_a_q, op_a_d;
    logic [3:0]  op_b_q, op_b_d;
    logic [23:0] run_cnt_q, run_cnt_d;
    logic        result_valid_q, result_valid_d;
    logic        timeout_err_q, timeout_err_d;

    always_comb begin
        state_d        = state_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        run_cnt_d      = run_cnt_q;
        result_valid_d = result_valid_q;
        timeout_err_d  = timeout_err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (go_q) begin
                    // The switches are static while the operator presses the
                    // button, so they are captured directly without a synchronizer.
                    op_a_d         = sw_a;
                    op_b_d         = sw_b;
                    result_valid_d = 1'b0;
                    timeout_err_d  = 1'b0;
                    state_d        = S_WRITE_A;
                end
            end
            S_WRITE_A: state_d = S_WRITE_B;
            S_WRITE_B: begin
                run_cnt_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                // cpu_done is tested first, so it wins on the timeout cycle.
                if (cpu_done) begin
                    result_valid_d = 1'b1;
                    state_d        = S_DONE;
                end else if (run_cnt_q == TIMEOUT - 24'd1) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    run_cnt_d = run_cnt_q + 24'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs, decoded from the next state so each one is a
    // flop output and is valid in the same cycle as the state it belongs to.
    // ------------------------------------------------------------------
    logic        dm_we_q, dm_we_d;
    logic [6:0]  dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic        cpu_run_q, cpu_run_d;
    logic        busy_q, busy_d;

    always_comb begin
        dm_we_d    = 1'b0;
        dm_addr_d  = '0;
        dm_wdata_d = '0;
        case (state_d)
            S_WRITE_A: begin
                dm_we_d    = 1'b1;
                dm_addr_d  = A_ADDR;
                dm_wdata_d = {28'd0, op_a_d};
            end
            S_WRITE_B: begin
                dm_we_d    = 1'b1;
                dm_addr_d  = B_ADDR;
                dm_wdata_d = {28'd0, op_b_d};
            end
            default: begin
                dm_we_d    = 1'b0;
                dm_addr_d  = '0;
                dm_wdata_d = '0;
            end
        endcase
        cpu_run_d = (state_d == S_RUN);
        busy_d    = (state_d == S_WRITE_A) || (state_d == S_WRITE_B) || (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            op_a_q         <= '0;
            op_b_q         <= '0;
            run_cnt_q      <= '0;
            result_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            dm_we_q        <= 1'b0;
            dm_addr_q      <= '0;
            dm_wdata_q     <= '0;
            cpu_run_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            run_cnt_q      <= run_cnt_d;
            result_valid_q <= result_valid_d;
            timeout_err_q  <= timeout_err_d;
            dm_we_q        <= dm_we_d;
            dm_addr_q      <= dm_addr_d;
            dm_wdata_q     <= dm_wdata_d;
            cpu_run_q      <= cpu_run_d;
            busy_q         <= busy_d;
        end
    end

    assign dm_we        = dm_we_q;
    assign dm_addr      = dm_addr_q;
    assign dm_wdata     = dm_wdata_q;
    assign cpu_run      = cpu_run_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign timeout_err  = timeout_err_q;
    assign dbg_state_o  = state_q;

endmodule
